// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: a - b - borrow_in, LSB first, one bit per clock,
// behind a start/done handshake with a registered difference and underflow flag.
module subtractor_serial #(
   parameter int unsigned BIT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 borrow_in,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_WIDTH-1:0] diff,
   output logic                 underflow
);

   localparam int unsigned CNT_W = ($clog2(BIT_WIDTH) < 1) ? 1 : $clog2(BIT_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0] a_sh_q, a_sh_d;
   logic [BIT_WIDTH-1:0] b_sh_q, b_sh_d;
   logic                 br_q, br_d;
   logic [BIT_WIDTH-1:0] res_q, res_d;
   logic [BIT_WIDTH-1:0] diff_q, diff_d;
   logic                 underflow_q, underflow_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 a_i, b_i, d_bit, br_nxt;
   logic [BIT_WIDTH-1:0] res_shifted;

   // One full-subtractor slice on the current LSBs
   always_comb begin
      a_i         = a_sh_q[0];
      b_i         = b_sh_q[0];
      d_bit       = a_i ^ b_i ^ br_q;
      br_nxt      = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
      res_shifted = {d_bit, res_q[BIT_WIDTH-1:1]};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      br_d        = br_q;
      res_d       = res_q;
      diff_d      = diff_q;
      underflow_d = underflow_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = borrow_in;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_nxt;
            res_d  = res_shifted;
            if (cnt_q == CNT_LAST) begin
               diff_d      = res_shifted;
               underflow_d = br_nxt;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Flags are registered copies of the next state
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         br_q        <= 1'b0;
         res_q       <= '0;
         diff_q      <= '0;
         underflow_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         br_q        <= br_d;
         res_q       <= res_d;
         diff_q      <= diff_d;
         underflow_q <= underflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign diff      = diff_q;
   assign underflow = underflow_q;

`ifndef SYNTHESIS
   // Flag X/Z on the handshake and on operands at the accepting edge
   always @(posedge clk) begin
      if (n_rst) begin
         assert (!$isunknown(start))
            else $error("subtractor_serial: start is X/Z");
         if (start && (state_q != RUN)) begin
            assert (!$isunknown({a, b, borrow_in}))
               else $error("subtractor_serial: operands X/Z on accept");
         end
      end
   end
`endif

endmodule
